i2s_master_tx: RTL and testbench
================================

Name: i2s_master_tx

Overview:
- I2S bus master transmitter. Generates the bit clock and LR clock and serialises stereo PCM frames onto a serial data line.
- It is the driving end of the BCLK/LRCK/DAT link consumed by the audio core's ADC-side receiver. The team uses it as a codec emulator in simulation and as an FPGA-mastered audio source.
- Frames arrive over a valid/ready stream into a 4-deep stereo FIFO.

Parameters:
- DATA_WIDTH, 24: PCM bits per channel; range 1..SLOT_WIDTH-1.
- SLOT_WIDTH, 32: BCLK periods per channel slot; one frame is 2*SLOT_WIDTH BCLK periods.
- BCLK_HALF, 16: CLOCK_50 cycles per BCLK half-period; must be ≥1.
- FIFO_DEPTH, 4: stereo frames buffered; must be a power of 2.

Ports:
- CLOCK_50  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- enable  in  1  run request; sampled every cycle.
- s_valid  in  1  input frame valid.
- s_ready  out  1  FIFO not full.
- s_left  in  DATA_WIDTH  left sample, two's complement.
- s_right  in  DATA_WIDTH  right sample.
- fifo_level  out  log2(FIFO_DEPTH)+1  frames stored.
- AUD_BCLK  out  1  bit clock.
- AUD_LRCK  out  1  0 = left slot, 1 = right slot.
- AUD_SDAT  out  1  serial data, MSB first.
- underrun  out  1  one-cycle pulse when a frame load finds the FIFO empty.

Behaviour:
- Reset (async, immediate, including mid-frame): FSM=IDLE; AUD_BCLK=0, AUD_LRCK=0, AUD_SDAT=0, underrun=0; FIFO emptied, so fifo_level=0 and s_ready=1; divider and bit counter cleared.
- FIFO:
  - Push when s_valid && s_ready; s_ready = (level < FIFO_DEPTH).
  - Pop occurs only at a frame load.
  - Push and pop in the same cycle leaves the level unchanged.
  - Pop from empty: no pop; shift registers load zeros; underrun pulses.
  - No bypass: a frame pushed in the same cycle as a load is not used by that load.
  - FIFO contents persist across enable toggles.
- Divider (RUN/DRAIN only): counter 0..BCLK_HALF-1. At wrap, AUD_BCLK toggles. A 1→0 toggle is a "falling event"; all LRCK/SDAT updates occur only on the cycle of a falling event.
- Bit index k (0..SLOT_WIDTH-1) within the current slot:
  - k=0: SDAT=0.
  - k=1..DATA_WIDTH: SDAT = sample[DATA_WIDTH-k].
  - k>DATA_WIDTH: SDAT=0.
  - This gives I2S one-BCLK delay after the LRCK edge, with zero padding.
- FSM:
  - IDLE: outputs held at reset values. When enable=1 → RUN next cycle, performing a frame load: latch left/right, LRCK=0, k=0, SDAT=0, divider=0, BCLK=0. The first BCLK rising edge occurs BCLK_HALF cycles later.
  - RUN, each falling event:
    - If k<SLOT_WIDTH-1: k++ and update SDAT.
    - Else if LRCK=0: LRCK=1, k=0, SDAT=0, start the right slot.
    - Else (end of frame): frame load, LRCK=0, k=0.
    - If enable=0 at any cycle → DRAIN.
  - DRAIN: identical to RUN, except at end of frame go to IDLE with no load: BCLK=0, LRCK=0, SDAT=0. Re-asserting enable during DRAIN returns to RUN without a glitch.
- Timing:
  - Frame period = 4*SLOT_WIDTH*BCLK_HALF cycles; exactly one load per frame.
  - A frame already in the FIFO at load appears at SDAT MSB 2*BCLK_HALF cycles after the load (at the k=1 falling event).
- underrun is asserted only in the load cycle; never in IDLE.

Test Plan:
(Parameters: BCLK_HALF=2, SLOT_WIDTH=32, DATA_WIDTH=24.)
- Basic frame: push L=0xA5A5A5, R=0x5A5A5A, then enable. Required response:
  - BCLK period 4 cycles; LRCK low for 32 BCLKs, then high for 32.
  - Sampled on BCLK rising edges, the left slot reads 0, 101001011010010110100101, then 7 zeros; the right slot reads the complement pattern.
  - No underrun.
- Underrun: enable with an empty FIFO → underrun pulses at the load cycle and every 256 cycles after; SDAT stays 0; fifo_level=0.
- Full/backpressure: with enable=0, assert s_valid for 6 cycles with distinct data → s_ready falls after the 4th push; fifo_level=4; frames 5–6 are dropped. Then enable → frames 1–4 are serialised in order, followed by an underrun.
- Drain: deassert enable during k=10 of the left slot → the right slot completes. Then BCLK=0, LRCK=0, SDAT=0; FSM idle; remaining FIFO frames are retained (fifo_level unchanged).
- Reset mid-frame: assert RESET_N low during the right slot → all outputs 0 and fifo_level=0 within the same cycle, asynchronously. After release, enable restarts cleanly at the left slot.
- Simultaneous push and load: with level=1, push in the exact load cycle → the loaded frame is the old entry, and level stays 1.

Source files
------------

// File: rtl/i2s_master_tx.sv
`default_nettype none
// =============================================================================
// i2s_master_tx : I2S bus master (BCLK/LRCK/SDAT) fed by a stereo frame FIFO
// Revision 1.0
// =============================================================================
module i2s_master_tx #(
   parameter int DATA_WIDTH = 24,
   parameter int SLOT_WIDTH = 32,
   parameter int BCLK_HALF  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          CLOCK_50,
   input  logic                          RESET_N,
   input  logic                          enable,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [DATA_WIDTH-1:0]         s_left,
   input  logic [DATA_WIDTH-1:0]         s_right,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          AUD_BCLK,
   output logic                          AUD_LRCK,
   output logic                          AUD_SDAT,
   output logic                          underrun
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
   localparam int K_W   = $clog2(SLOT_WIDTH);

   localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(BCLK_HALF - 1);
   localparam logic [K_W-1:0]   C_K_LAST   = K_W'(SLOT_WIDTH - 1);
   localparam logic [K_W-1:0]   C_K_DATA   = K_W'(DATA_WIDTH);
   localparam logic [LVL_W-1:0] C_LVL_FULL = LVL_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // ---------------------------------------------------------------- FIFO
   logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]        level_q, level_d;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_nonempty;

   // ---------------------------------------------------------------- serialiser
   logic [1:0]              state_q, state_d;
   logic [DIV_W-1:0]        div_q, div_d;
   logic [K_W-1:0]          k_q, k_d;
   logic [K_W-1:0]          w_k_next;
   logic                    bclk_q, bclk_d;
   logic                    lrck_q, lrck_d;
   logic                    sdat_q, sdat_d;
   logic                    underrun_q, underrun_d;
   logic [DATA_WIDTH-1:0]   sh_q, sh_d;
   logic [DATA_WIDTH-1:0]   rhold_q, rhold_d;

   logic                    w_active;
   logic                    w_tick;
   logic                    w_fall;
   logic                    w_slot_end;
   logic                    w_frame_end;
   logic                    w_load;
   logic                    w_stop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == C_PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign s_ready    = (level_q < C_LVL_FULL);
   assign w_nonempty = (level_q != '0);
   assign w_push     = s_valid & s_ready;
   assign w_pop      = w_load & w_nonempty;

   always_comb begin
      wr_ptr_d = w_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = w_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      level_d  = level_q;
      case ({w_push, w_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= {s_left, s_right};
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Every LRCK/SDAT change is aligned to a BCLK falling event.
   assign w_active    = (state_q != ST_IDLE);
   assign w_tick      = (div_q == C_DIV_LAST);
   assign w_fall      = w_active & w_tick & bclk_q;
   assign w_slot_end  = (k_q == C_K_LAST);
   assign w_frame_end = w_fall & w_slot_end & lrck_q;
   assign w_load      = ((state_q == ST_IDLE) & enable) |
                        (w_frame_end & ((state_q == ST_RUN) | enable));
   assign w_stop      = w_frame_end & ~w_load;
   assign w_k_next    = k_q + 1'b1;

   // ---------------------------------------------------------------- FSM: state register
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!enable) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_stop)      state_d = ST_IDLE;
            else if (enable) state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- FSM: outputs / datapath
   always_comb begin
      div_d      = div_q;
      bclk_d     = bclk_q;
      lrck_d     = lrck_q;
      k_d        = k_q;
      sdat_d     = sdat_q;
      sh_d       = sh_q;
      rhold_d    = rhold_q;
      underrun_d = 1'b0;
      if (w_load) begin
         div_d  = '0;
         bclk_d = 1'b0;
         lrck_d = 1'b0;
         k_d    = '0;
         sdat_d = 1'b0;
         if (w_nonempty) begin
            {sh_d, rhold_d} = mem_q[rd_ptr_q];
         end else begin
            sh_d       = '0;
            rhold_d    = '0;
            underrun_d = 1'b1;
         end
      end else if (w_stop) begin
         div_d  = '0;
         bclk_d = 1'b0;
         lrck_d = 1'b0;
         k_d    = '0;
         sdat_d = 1'b0;
      end else if (w_active) begin
         if (w_tick) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
         end else begin
            div_d  = div_q + 1'b1;
         end
         if (w_fall) begin
            if (!w_slot_end) begin
               k_d = w_k_next;
               if (w_k_next <= C_K_DATA) begin
                  sdat_d = sh_q[DATA_WIDTH-1];
                  sh_d   = sh_q << 1;
               end else begin
                  sdat_d = 1'b0;
               end
            end else begin
               // End of the left slot: the right sample takes over the shifter.
               lrck_d = 1'b1;
               k_d    = '0;
               sdat_d = 1'b0;
               sh_d   = rhold_q;
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         div_q      <= '0;
         bclk_q     <= 1'b0;
         lrck_q     <= 1'b0;
         k_q        <= '0;
         sdat_q     <= 1'b0;
         sh_q       <= '0;
         rhold_q    <= '0;
         underrun_q <= 1'b0;
      end else begin
         div_q      <= div_d;
         bclk_q     <= bclk_d;
         lrck_q     <= lrck_d;
         k_q        <= k_d;
         sdat_q     <= sdat_d;
         sh_q       <= sh_d;
         rhold_q    <= rhold_d;
         underrun_q <= underrun_d;
      end
   end

   assign fifo_level = level_q;
   assign AUD_BCLK   = bclk_q;
   assign AUD_LRCK   = lrck_q;
   assign AUD_SDAT   = sdat_q;
   assign underrun   = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_master_tx.sv
`default_nettype none
// =============================================================================
// tb_i2s_master_tx : scoreboard bench for i2s_master_tx (BCLK_HALF=2)
// Revision 1.0
// =============================================================================
module tb_i2s_master_tx;

   localparam int BH = 2;

   logic        CLOCK_50 = 1'b0;
   logic        RESET_N  = 1'b0;
   logic        enable   = 1'b0;
   logic        s_valid  = 1'b0;
   logic        s_ready;
   logic [23:0] s_left   = '0;
   logic [23:0] s_right  = '0;
   logic [2:0]  fifo_level;
   logic        AUD_BCLK;
   logic        AUD_LRCK;
   logic        AUD_SDAT;
   logic        underrun;

   i2s_master_tx #(
      .DATA_WIDTH (24),
      .SLOT_WIDTH (32),
      .BCLK_HALF  (BH),
      .FIFO_DEPTH (4)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .RESET_N    (RESET_N),
      .enable     (enable),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_left     (s_left),
      .s_right    (s_right),
      .fifo_level (fifo_level),
      .AUD_BCLK   (AUD_BCLK),
      .AUD_LRCK   (AUD_LRCK),
      .AUD_SDAT   (AUD_SDAT),
      .underrun   (underrun)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_q [$];
   int          ur_cnt   = 0;
   int          mdl_lvl  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Frame as seen on BCLK rising edges: one delay bit, 24 data bits, 7 pad bits per slot.
   function automatic logic [63:0] frame_word(input logic [23:0] l, input logic [23:0] r);
      return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
   endfunction

   // ---------------------------------------------------------------- monitor
   int          cyc        = 0;
   int          last_rise  = 0;
   int          idx        = 0;
   int          per_bad    = 0;
   bit          collecting = 0;
   bit          last_lr    = 1;
   bit          prev_bclk  = 0;
   bit          prev_ur    = 0;
   logic [63:0] fbits      = '0;
   logic [63:0] lbits      = '0;

   always @(negedge CLOCK_50) begin
      cyc++;
      if (!RESET_N) begin
         collecting = 0;
         last_lr    = 1;
         prev_bclk  = 0;
         idx        = 0;
      end else begin
         if (AUD_BCLK && !prev_bclk) begin
            if (!AUD_LRCK && last_lr) begin
               collecting = 1;
               idx        = 0;
               fbits      = '0;
               lbits      = '0;
               per_bad    = 0;
            end else if (collecting && (cyc - last_rise) != 2 * BH) begin
               per_bad++;
            end
            last_rise = cyc;
            last_lr   = AUD_LRCK;
            if (collecting) begin
               fbits = {fbits[62:0], AUD_SDAT};
               lbits = {lbits[62:0], AUD_LRCK};
               idx++;
               if (idx == 64) begin
                  collecting = 0;
                  if (exp_q.size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL unexpected_frame: got %0h, required no frame", fbits);
                  end else begin
                     check("frame_data", fbits, exp_q.pop_front());
                     check("frame_lrck", lbits, 64'h00000000_FFFFFFFF);
                     check("bclk_period_errors", 64'(per_bad), 64'd0);
                  end
               end
            end
         end
         prev_bclk = AUD_BCLK;
      end
      if (underrun && !prev_ur) ur_cnt++;
      prev_ur = underrun;
   end

   // ---------------------------------------------------------------- stimulus helpers
   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic push_frame(input logic [23:0] l, input logic [23:0] r);
      s_valid = 1'b1;
      s_left  = l;
      s_right = r;
      if (mdl_lvl < 4) begin
         exp_q.push_back(frame_word(l, r));
         mdl_lvl++;
      end
      tick(1);
      s_valid = 1'b0;
   endtask

   task automatic wait_underrun(input int bound, input string name);
      bit found = 0;
      for (int i = 0; i < bound && !found; i++) begin
         @(negedge CLOCK_50);
         if (underrun) found = 1;
      end
      if (!found) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got no underrun pulse, required one within %0d cycles", name, bound);
      end
   endtask

   task automatic check_idle(input string tag, input int lvl);
      check({tag, "_bclk"},  64'(AUD_BCLK),   64'd0);
      check({tag, "_lrck"},  64'(AUD_LRCK),   64'd0);
      check({tag, "_sdat"},  64'(AUD_SDAT),   64'd0);
      check({tag, "_level"}, 64'(fifo_level), 64'(lvl));
   endtask

   logic [23:0] fl [6] = '{24'h123456, 24'hFEDCBA, 24'h800001, 24'h7FFFFE, 24'h0F0F0F, 24'hF0F0F0};
   logic [23:0] fr [6] = '{24'h654321, 24'h000001, 24'hFFFFFF, 24'h3C3C3C, 24'hAAAAAA, 24'h555555};

   initial begin
      time t1;
      time t2;

      // Reset state
      tick(3);
      check_idle("reset", 0);
      check("reset_ready",    64'(s_ready),  64'd1);
      check("reset_underrun", 64'(underrun), 64'd0);
      RESET_N = 1'b1;
      tick(2);

      // Basic frame, drained after one frame
      s_valid = 1'b1;
      s_left  = 24'hA5A5A5;
      s_right = 24'h5A5A5A;
      exp_q.push_back(64'h52D2D280_2D2D2D00);
      mdl_lvl = 1;
      tick(1);
      s_valid = 1'b0;
      check("basic_level", 64'(fifo_level), 64'd1);
      enable = 1'b1;
      tick(20);
      enable = 1'b0;
      mdl_lvl = 0;
      tick(300);
      check_idle("basic_end", 0);
      check("basic_no_underrun", 64'(ur_cnt), 64'd0);
      check("basic_consumed", 64'(exp_q.size()), 64'd0);

      // Underrun with an empty FIFO: two zero frames, pulses 256 cycles apart
      exp_q.push_back(64'd0);
      exp_q.push_back(64'd0);
      enable = 1'b1;
      wait_underrun(10, "underrun_first");
      t1 = $time;
      check("underrun_level", 64'(fifo_level), 64'd0);
      wait_underrun(300, "underrun_second");
      t2 = $time;
      enable = 1'b0;
      check("underrun_interval", 64'((t2 - t1) / 10), 64'd256);
      tick(300);
      check_idle("underrun_end", 0);
      check("underrun_count", 64'(ur_cnt), 64'd2);

      // Backpressure: six offered frames, four accepted
      for (int i = 0; i < 6; i++) begin
         push_frame(fl[i], fr[i]);
         check("fill_ready", 64'(s_ready),    64'(mdl_lvl < 4));
         check("fill_level", 64'(fifo_level), 64'(mdl_lvl));
      end
      exp_q.push_back(64'd0);
      enable = 1'b1;
      wait_underrun(5 * 256 + 50, "full_underrun");
      enable = 1'b0;
      mdl_lvl = 0;
      tick(300);
      check_idle("full_end", 0);
      check("full_underrun_count", 64'(ur_cnt), 64'd3);

      // Drain: enable drops during k=10 of the left slot
      push_frame(24'h111111, 24'h999999);
      push_frame(24'h222222, 24'hAAAAAB);
      push_frame(24'h333333, 24'hCCCCCD);
      enable = 1'b1;
      @(posedge CLOCK_50);
      tick(41);
      enable = 1'b0;
      tick(300);
      check_idle("drain_end", 2);
      check("drain_no_underrun", 64'(ur_cnt), 64'd3);

      // Asynchronous reset during the right slot
      enable = 1'b1;
      @(posedge CLOCK_50);
      tick(148);
      check("pre_reset_lrck", 64'(AUD_LRCK), 64'd1);
      #3;
      RESET_N = 1'b0;
      enable  = 1'b0;
      #1;
      check_idle("async_reset", 0);
      check("async_reset_ready", 64'(s_ready), 64'd1);
      exp_q.delete();
      mdl_lvl = 0;
      tick(3);
      RESET_N = 1'b1;
      tick(2);
      push_frame(24'hC0FFEE, 24'h0BADF0);
      enable = 1'b1;
      tick(20);
      enable = 1'b0;
      tick(300);
      check_idle("restart_end", 0);

      // Push in the exact load cycle: old entry is loaded, level stays at one
      push_frame(24'hABCDEF, 24'h13579B);
      enable  = 1'b1;
      s_valid = 1'b1;
      s_left  = 24'h2468AC;
      s_right = 24'hFDB975;
      exp_q.push_back(frame_word(24'h2468AC, 24'hFDB975));
      tick(1);
      s_valid = 1'b0;
      check("simul_level", 64'(fifo_level), 64'd1);
      tick(20);
      enable = 1'b0;
      tick(300);
      check_idle("simul_end", 1);
      enable = 1'b1;
      tick(20);
      enable = 1'b0;
      tick(300);
      check_idle("simul_flush_end", 0);

      check("total_underruns", 64'(ur_cnt), 64'd3);
      check("frames_outstanding", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
